// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit driving the regfile write port
// Optional early completion of trivial/special ops: define MDU_EARLY_OUT_EN.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      dst,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic            rd_w,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_in
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]     cnt;
    logic [2:0]        f3_q;
    logic [4:0]        dst_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi, lo, dv;

    logic              signed_a, signed_b, sa, sb, b_zero, neg_in, last;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_cur, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   dval, dval_f, result;

    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sa       = signed_a & op_a[XLEN-1];
        sb       = signed_b & op_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        b_zero   = (op_b == '0);
        // A zero divisor yields an all-ones quotient, so its sign must not be applied.
        if (!funct3[2])
            neg_in = sa ^ sb;
        else if (funct3[1])
            neg_in = sa;
        else
            neg_in = (sa ^ sb) & ~b_zero;
    end

`ifdef MDU_EARLY_OUT_EN
    logic            early, ovf;
    logic [XLEN-1:0] early_hi, early_lo;
    always_comb begin
        ovf      = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        early    = funct3[2] ? (b_zero | ovf) : ((op_a == '0) | b_zero);
        early_hi = (funct3[2] && b_zero) ? mag_a : '0;
        early_lo = funct3[2] ? (b_zero ? '1 : mag_a) : '0;
    end
`endif

    always_comb begin
        last     = (cnt == CW'(XLEN));
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
        div_cur  = {hi, lo[XLEN-1]};
        div_ge   = (div_cur >= {1'b0, dv});
        div_diff = div_cur - {1'b0, dv};
        prod     = {hi, lo};
        prod_f   = neg_q ? -prod : prod;
        dval     = f3_q[1] ? hi : lo;
        dval_f   = neg_q ? -dval : dval;
        if (f3_q[2])
            result = dval_f;
        else if (f3_q[1:0] == 2'b00)
            result = prod_f[XLEN-1:0];
        else
            result = prod_f[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            f3_q  <= '0;
            dst_q <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            dv    <= '0;
            rd    <= '0;
            rd_in <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    f3_q  <= funct3;
                    dst_q <= dst;
                    neg_q <= neg_in;
                    cnt   <= '0;
                    hi    <= '0;
                    lo    <= funct3[2] ? mag_a : mag_b;
                    dv    <= funct3[2] ? mag_b : mag_a;
`ifdef MDU_EARLY_OUT_EN
                    // Preload the raw result and jump the counter straight to the final step.
                    if (early) begin
                        cnt <= CW'(XLEN);
                        hi  <= early_hi;
                        lo  <= early_lo;
                    end
`endif
                end
                RUN: if (last) begin
                    rd    <= dst_q;
                    rd_in <= result;
                end else begin
                    cnt <= cnt + CW'(1);
                    if (f3_q[2]) begin
                        hi <= div_ge ? div_diff[XLEN-1:0] : div_cur[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign rd_w = done && (rd != 5'd0);
endmodule
